// File: rtl/demux4_route_ctrl.sv
// rtl/demux4_route_ctrl.sv - 1-to-4 demux sequencing controller with addressed/round-robin routing
module demux4_route_ctrl #(
  parameter int DW      = 8,
  parameter int TIMEOUT = 15,
  parameter int CNTW    = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DW-1:0]     in_data,
  input  logic [1:0]        in_dest,
  input  logic              rr_mode,
  output logic [3:0]        out_valid,
  input  logic [3:0]        out_ready,
  output logic [DW-1:0]     out_data,
  output logic              sel_s0,
  output logic              sel_s1,
  output logic              busy,
  output logic [4*CNTW-1:0] sent_cnt
);

  typedef enum logic {IDLE, SEND} state_t;

  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  state_t          state_q, state_d;
  logic [DW-1:0]   data_q, data_d;
  logic [1:0]      sel_q, sel_d;
  logic [1:0]      rr_ptr_q, rr_ptr_d;
  logic [7:0]      wait_q, wait_d;
  logic            mode_q, mode_d;
  logic [CNTW-1:0] cnt_q [4];
  logic [CNTW-1:0] cnt_d [4];
  logic            xfer;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      data_q   <= '0;
      sel_q    <= '0;
      rr_ptr_q <= '0;
      wait_q   <= '0;
      mode_q   <= 1'b0;
      for (int c = 0; c < 4; c++) cnt_q[c] <= '0;
    end else begin
      state_q  <= state_d;
      data_q   <= data_d;
      sel_q    <= sel_d;
      rr_ptr_q <= rr_ptr_d;
      wait_q   <= wait_d;
      mode_q   <= mode_d;
      for (int c = 0; c < 4; c++) cnt_q[c] <= cnt_d[c];
    end
  end

  always_comb begin
    state_d  = state_q;
    data_d   = data_q;
    sel_d    = sel_q;
    rr_ptr_d = rr_ptr_q;
    wait_d   = wait_q;
    mode_d   = mode_q;
    for (int c = 0; c < 4; c++) cnt_d[c] = cnt_q[c];
    xfer     = (state_q == SEND) && out_ready[sel_q];

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          data_d  = in_data;
          mode_d  = rr_mode;
          sel_d   = rr_mode ? rr_ptr_q : in_dest;
          wait_d  = '0;
          state_d = SEND;
        end
      end
      SEND: begin
        // Transfer takes priority over a coincident timeout.
        if (xfer) begin
          cnt_d[sel_q] = cnt_q[sel_q] + CNTW'(1);
          if (mode_q) rr_ptr_d = sel_q + 2'd1;
          state_d = IDLE;
        end else if (mode_q) begin
          if (wait_q == WAIT_LAST) begin
            sel_d  = sel_q + 2'd1;
            wait_d = '0;
          end else begin
            wait_d = wait_q + 8'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == IDLE);
    busy      = (state_q == SEND);
    out_valid = (state_q == SEND) ? (4'b0001 << sel_q) : 4'b0000;
    out_data  = data_q;
    sel_s0    = sel_q[1];
    sel_s1    = sel_q[0];
    for (int c = 0; c < 4; c++) sent_cnt[c*CNTW +: CNTW] = cnt_q[c];
  end

endmodule

// File: tb/tb_demux4_route_ctrl.sv
// tb/tb_demux4_route_ctrl.sv - scoreboard bench for demux4_route_ctrl
module tb_demux4_route_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic [1:0]  in_dest;
  logic        rr_mode;
  logic [3:0]  out_valid;
  logic [3:0]  out_ready;
  logic [7:0]  out_data;
  logic        sel_s0, sel_s1, busy;
  logic [31:0] sent_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct packed { logic [1:0] ch; logic [7:0] data; } exp_t;
  exp_t exp_q[$];

  demux4_route_ctrl #(.DW(8), .TIMEOUT(15), .CNTW(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_dest(in_dest), .rr_mode(rr_mode),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .sel_s0(sel_s0), .sel_s1(sel_s1), .busy(busy), .sent_cnt(sent_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on every completed channel handshake.
  always @(negedge clk) begin
    if (!rst && ((out_valid & out_ready) != 4'b0000)) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_xfer", {28'h0, out_valid}, 32'h0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("xfer_chan", {30'h0, sel_s0, sel_s1}, {30'h0, e.ch});
        chk("xfer_data", {24'h0, out_data}, {24'h0, e.data});
        chk("xfer_onehot", {28'h0, out_valid}, 32'h1 << e.ch);
      end
    end
  end

  task automatic send(input logic [1:0] dest, input logic [7:0] data, input logic mode,
                      input logic [1:0] exp_ch);
    exp_t e;
    in_valid = 1'b1;
    in_data  = data;
    in_dest  = dest;
    rr_mode  = mode;
    e.ch     = exp_ch;
    e.data   = data;
    exp_q.push_back(e);
    @(negedge clk);
    chk("in_ready_before_accept", {31'h0, in_ready}, 32'h1);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_idle(input int bound);
    int k;
    k = 0;
    while (k < bound) begin
      @(negedge clk);
      if (in_ready) break;
      k++;
    end
    if (k >= bound) chk("wait_idle_timeout", 32'h1, 32'h0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int  cnt;
    logic ok;
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_dest = '0; rr_mode = 1'b0;
    out_ready = 4'b0000;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", {31'h0, in_ready}, 32'h1);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_out_valid", {28'h0, out_valid}, 32'h0);
    chk("rst_sel", {30'h0, sel_s0, sel_s1}, 32'h0);
    chk("rst_out_data", {24'h0, out_data}, 32'h0);
    chk("rst_sent_cnt", sent_cnt, 32'h0);
    @(posedge clk); #1;

    // Addressed mode to ch2
    out_ready = 4'b1111;
    send(2'd2, 8'hA5, 1'b0, 2'd2);
    @(negedge clk);
    chk("addr_out_valid", {28'h0, out_valid}, 32'h4);
    chk("addr_sel", {30'h0, sel_s0, sel_s1}, 32'h2);
    chk("addr_out_data", {24'h0, out_data}, 32'hA5);
    chk("addr_in_ready", {31'h0, in_ready}, 32'h0);
    wait_idle(10);
    chk("addr_cnt", sent_cnt, 32'h0001_0000);

    // Round-robin sweep
    send(2'd3, 8'h11, 1'b1, 2'd0); wait_idle(10);
    send(2'd3, 8'h22, 1'b1, 2'd1); wait_idle(10);
    send(2'd3, 8'h33, 1'b1, 2'd2); wait_idle(10);
    send(2'd3, 8'h44, 1'b1, 2'd3); wait_idle(10);
    chk("rr_cnt4", sent_cnt, 32'h0102_0101);
    send(2'd3, 8'h55, 1'b1, 2'd0); wait_idle(10);
    chk("rr_cnt5", sent_cnt, 32'h0102_0102);

    // Round-robin timeout: rr_ptr = 1, ch1 stalled
    out_ready = 4'b1101;
    send(2'd0, 8'h66, 1'b1, 2'd2);
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid != 4'b0010) break;
      cnt++;
    end
    chk("to_stall_cycles", cnt, 32'd15);
    chk("to_retarget_valid", {28'h0, out_valid}, 32'h4);
    wait_idle(10);
    chk("to_cnt", sent_cnt, 32'h0103_0102);
    out_ready = 4'b1111;
    send(2'd0, 8'h67, 1'b1, 2'd3); wait_idle(10);
    chk("to_rrptr3_cnt", sent_cnt, 32'h0203_0102);

    // Addressed stall: no timeout, mode/dest changes ignored
    out_ready = 4'b0000;
    send(2'd3, 8'h77, 1'b0, 2'd3);
    in_dest = 2'd0; rr_mode = 1'b1;
    ok = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid != 4'b1000 || in_ready != 1'b0) ok = 1'b0;
    end
    chk("addr_stall_hold", {31'h0, ok}, 32'h1);
    @(posedge clk);
    #1 out_ready = 4'b1000;
    wait_idle(10);
    chk("addr_stall_cnt", sent_cnt, 32'h0303_0102);

    // Counter wrap after a reset clears counters
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    chk("wrap_cleared", sent_cnt, 32'h0);
    out_ready = 4'b1111;
    for (int i = 0; i < 256; i++) begin
      send(2'd0, 8'(i), 1'b0, 2'd0);
      wait_idle(10);
      if (i == 254) chk("wrap_cnt_255", sent_cnt, 32'h0000_00FF);
    end
    chk("wrap_cnt_0", sent_cnt, 32'h0);

    // Reset mid-SEND discards the held word
    out_ready = 4'b0000;
    send(2'd0, 8'h99, 1'b0, 2'd0);
    @(negedge clk);
    chk("midrst_valid_before", {28'h0, out_valid}, 32'h1);
    @(posedge clk);
    #1 rst = 1'b1;
    exp_q.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("midrst_out_valid", {28'h0, out_valid}, 32'h0);
    chk("midrst_in_ready", {31'h0, in_ready}, 32'h1);
    chk("midrst_sel", {30'h0, sel_s0, sel_s1}, 32'h0);
    chk("midrst_cnt", sent_cnt, 32'h0);
    chk("midrst_data", {24'h0, out_data}, 32'h0);

    repeat (3) @(posedge clk);
    chk("scoreboard_empty", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
